// File: rtl/io_poll_master.sv
// Bus master: polls a status register until ready, reads two switch bytes,
// and writes their sum to the LED register, aborting after too many polls.
module io_poll_master #(
    parameter int POLL_INTERVAL = 4,
    parameter int TIMEOUT_POLLS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic [11:0] result,
    output logic        pread,
    output logic        pwrite,
    output logic [1:0]  addr,
    output logic [11:0] pwritedata,
    input  logic [31:0] preaddata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL_RD,
        S_POLL_WAIT,
        S_RD_HI,
        S_RD_LO,
        S_WR_LED,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0]  GAP_LOAD = 8'(POLL_INTERVAL - 1);
    localparam logic [15:0] POLL_LAST = 16'(TIMEOUT_POLLS - 1);

    localparam logic [1:0] A_STAT = 2'b00;
    localparam logic [1:0] A_LED  = 2'b01;
    localparam logic [1:0] A_SWLO = 2'b10;
    localparam logic [1:0] A_SWHI = 2'b11;

    state_t      state_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [11:0] result_q;
    logic        pread_q;
    logic        pwrite_q;
    logic [1:0]  addr_q;
    logic [11:0] wdata_q;
    logic [7:0]  hi_q;
    logic [7:0]  lo_q;
    logic [15:0] poll_cnt_q;
    logic [7:0]  gap_q;
    logic [8:0]  sum_d;
    logic        unused_bits;

    // lo is consumed straight off the bus so the sum is ready in WR_LED
    assign sum_d = {1'b0, hi_q} + {1'b0, preaddata[7:0]};
    assign unused_bits = ^{preaddata[31:8], lo_q};

    // Outputs are registered from the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            result_q   <= '0;
            pread_q    <= 1'b0;
            pwrite_q   <= 1'b0;
            addr_q     <= A_STAT;
            wdata_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            poll_cnt_q <= '0;
            gap_q      <= '0;
        end else begin
            pread_q  <= 1'b0;
            pwrite_q <= 1'b0;
            addr_q   <= A_STAT;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (start) begin
                        state_q    <= S_POLL_RD;
                        err_q      <= 1'b0;
                        poll_cnt_q <= '0;
                        pread_q    <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                S_POLL_RD: begin
                    if (preaddata[1]) begin
                        state_q <= S_RD_HI;
                        pread_q <= 1'b1;
                        addr_q  <= A_SWHI;
                    end else if (poll_cnt_q == POLL_LAST) begin
                        state_q <= S_ERR;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        state_q    <= S_POLL_WAIT;
                        poll_cnt_q <= poll_cnt_q + 16'd1;
                        gap_q      <= GAP_LOAD;
                    end
                end
                S_POLL_WAIT: begin
                    if (gap_q == 8'd0) begin
                        state_q <= S_POLL_RD;
                        pread_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q - 8'd1;
                    end
                end
                S_RD_HI: begin
                    hi_q    <= preaddata[7:0];
                    state_q <= S_RD_LO;
                    pread_q <= 1'b1;
                    addr_q  <= A_SWLO;
                end
                S_RD_LO: begin
                    lo_q     <= preaddata[7:0];
                    state_q  <= S_WR_LED;
                    pwrite_q <= 1'b1;
                    addr_q   <= A_LED;
                    wdata_q  <= {3'b000, sum_d};
                    result_q <= {3'b000, sum_d};
                end
                S_WR_LED: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                S_DONE, S_ERR: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = err_q;
    assign result      = result_q;
    assign pread       = pread_q;
    assign pwrite      = pwrite_q;
    assign addr        = addr_q;
    assign pwritedata  = wdata_q;

endmodule

// File: tb/tb_io_poll_master.sv
// Scoreboard bench for io_poll_master: a small instance (interval 2,
// timeout 4) with a bus model, plus a default instance for long timeouts.
module tb_io_poll_master;

    localparam int PI_A = 2;
    localparam int TP_A = 4;

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  kind;
        logic [1:0]  addr;
        logic [11:0] data;
        logic        err;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;

    logic        busy_a, done_a, timeout_err_a, pread_a, pwrite_a;
    logic [11:0] result_a, pwritedata_a;
    logic [1:0]  addr_a;
    logic [31:0] pd_a;

    logic        busy_b, done_b, timeout_err_b, pread_b, pwrite_b;
    logic [11:0] result_b, pwritedata_b;
    logic [1:0]  addr_b;
    logic [31:0] pd_b;

    int          cyc = 0;
    int          nrd_a = 0;
    int          rd_base = 0;
    int          ready_at = 0;
    logic [7:0]  hi_v = 8'h00;
    logic [7:0]  lo_v = 8'h00;
    logic [11:0] exp_result = 12'h000;

    int          vecs = 0;
    int          errs = 0;
    ev_t         sb[$];
    ev_t         obs[$];

    io_poll_master #(
        .POLL_INTERVAL(PI_A),
        .TIMEOUT_POLLS(TP_A)
    ) dut_a (
        .clk(clk),
        .reset(reset),
        .start(start_a),
        .busy(busy_a),
        .done(done_a),
        .timeout_err(timeout_err_a),
        .result(result_a),
        .pread(pread_a),
        .pwrite(pwrite_a),
        .addr(addr_a),
        .pwritedata(pwritedata_a),
        .preaddata(pd_a)
    );

    io_poll_master dut_b (
        .clk(clk),
        .reset(reset),
        .start(start_b),
        .busy(busy_b),
        .done(done_b),
        .timeout_err(timeout_err_b),
        .result(result_b),
        .pread(pread_b),
        .pwrite(pwrite_b),
        .addr(addr_b),
        .pwritedata(pwritedata_b),
        .preaddata(pd_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pread_a && addr_a == 2'b00)
            nrd_a <= nrd_a + 1;
    end

    // Status ready once ready_at polls have been made; junk in upper bits
    always_comb begin
        pd_a = 32'hFFFF_FFFF;
        case (addr_a)
            2'b00: pd_a = {24'hC35A96,
                           ((nrd_a - rd_base) >= ready_at) ? 8'hFE : 8'hFD};
            2'b11: pd_a = {24'h9ABCDE, hi_v};
            2'b10: pd_a = {24'h13579B, lo_v};
            default: pd_a = 32'hFFFF_FFFF;
        endcase
    end

    assign pd_b = 32'h1234_56FD;

    always @(negedge clk) begin
        if (!reset && (pread_a || pwrite_a || done_a)) begin
            ev_t g;
            g.cyc  = 32'(cyc);
            g.kind = (pread_a && pwrite_a) ? 2'd3 :
                     pwrite_a ? 2'd1 : (done_a && !pread_a) ? 2'd2 : 2'd0;
            g.addr = (pread_a || pwrite_a) ? addr_a : 2'd0;
            g.data = pwrite_a ? pwritedata_a :
                     (done_a && !pread_a) ? result_a : 12'd0;
            g.err  = timeout_err_a;
            obs.push_back(g);
        end
    end

    function automatic ev_t mk(int c, logic [1:0] k, logic [1:0] a,
                               logic [11:0] d, logic e);
        ev_t r;
        r.cyc  = 32'(c);
        r.kind = k;
        r.addr = a;
        r.data = d;
        r.err  = e;
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vecs++;
        if ({busy_a, done_a, timeout_err_a, result_a, pread_a, pwrite_a,
             addr_a, pwritedata_a} !== 31'd0) begin
            errs++;
            $display("FAIL reset_a: got busy=%b done=%b err=%b res=%h rd=%b wr=%b addr=%0d wd=%h, need all 0",
                     busy_a, done_a, timeout_err_a, result_a, pread_a,
                     pwrite_a, addr_a, pwritedata_a);
        end
        vecs++;
        if ({busy_b, done_b, timeout_err_b, result_b, pread_b, pwrite_b,
             addr_b, pwritedata_b} !== 31'd0) begin
            errs++;
            $display("FAIL reset_b: got busy=%b done=%b err=%b res=%h, need all 0",
                     busy_b, done_b, timeout_err_b, result_b);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Expected events come from the bus timing model, not from the DUT
    task automatic test_txn(input string name, input logic [7:0] hi,
                            input logic [7:0] lo, input int rdy,
                            input logic [31:0] mask);
        int base;
        int nr;
        int last;
        int c;
        logic [8:0] s;
        bit to;
        ev_t e;
        ev_t g;
        @(negedge clk);
        obs.delete();
        sb.delete();
        hi_v = hi;
        lo_v = lo;
        ready_at = rdy;
        rd_base = nrd_a;
        base = cyc;
        to = (rdy >= TP_A);
        nr = to ? TP_A : rdy + 1;
        for (int k = 0; k < nr; k++)
            sb.push_back(mk(base + 1 + k * (PI_A + 1), 2'd0, 2'd0, 12'd0, 1'b0));
        last = base + 1 + (nr - 1) * (PI_A + 1);
        s = {1'b0, hi} + {1'b0, lo};
        if (to) begin
            sb.push_back(mk(last + 1, 2'd2, 2'd0, exp_result, 1'b1));
        end else begin
            sb.push_back(mk(last + 1, 2'd0, 2'd3, 12'd0, 1'b0));
            sb.push_back(mk(last + 2, 2'd0, 2'd2, 12'd0, 1'b0));
            sb.push_back(mk(last + 3, 2'd1, 2'd1, {3'b000, s}, 1'b0));
            sb.push_back(mk(last + 4, 2'd2, 2'd0, {3'b000, s}, 1'b0));
            exp_result = {3'b000, s};
        end
        start_a = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            c = cyc - base;
            start_a = (c >= 0 && c < 32) ? mask[c] : 1'b0;
            if (cyc > last + 6)
                break;
        end
        start_a = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            vecs++;
            if (obs.size() == 0) begin
                errs++;
                $display("FAIL %s missing: need cyc=%0d kind=%0d addr=%0d data=%h err=%b",
                         name, e.cyc, e.kind, e.addr, e.data, e.err);
            end else begin
                g = obs.pop_front();
                if (g !== e) begin
                    errs++;
                    $display("FAIL %s event: got cyc=%0d kind=%0d addr=%0d data=%h err=%b, need cyc=%0d kind=%0d addr=%0d data=%h err=%b",
                             name, g.cyc, g.kind, g.addr, g.data, g.err,
                             e.cyc, e.kind, e.addr, e.data, e.err);
                end
            end
        end
        while (obs.size() > 0) begin
            g = obs.pop_front();
            vecs++;
            errs++;
            $display("FAIL %s extra: got cyc=%0d kind=%0d addr=%0d data=%h, need none",
                     name, g.cyc, g.kind, g.addr, g.data);
        end
        vecs++;
        if (busy_a !== 1'b0) begin
            errs++;
            $display("FAIL %s busy_end: got %b, need 0", name, busy_a);
        end
        vecs++;
        if (result_a !== exp_result) begin
            errs++;
            $display("FAIL %s result: got %h, need %h", name, result_a, exp_result);
        end
        vecs++;
        if (timeout_err_a !== to) begin
            errs++;
            $display("FAIL %s timeout_err: got %b, need %b", name, timeout_err_a, to);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        logic [1:0] ad [3];
        ev_t g;
        ad[0] = 2'd0;
        ad[1] = 2'd3;
        ad[2] = 2'd2;
        @(negedge clk);
        obs.delete();
        hi_v = 8'h44;
        lo_v = 8'h55;
        ready_at = 0;
        rd_base = nrd_a;
        base = cyc;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        vecs++;
        if ({pread_a, pwrite_a, busy_a, done_a} !== 4'b0000) begin
            errs++;
            $display("FAIL reset_mid strobes: got rd=%b wr=%b busy=%b done=%b, need 0000",
                     pread_a, pwrite_a, busy_a, done_a);
        end
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        exp_result = 12'h000;
        vecs++;
        if (obs.size() != 3) begin
            errs++;
            $display("FAIL reset_mid count: got %0d events, need 3", obs.size());
        end
        for (int i = 0; i < 3 && obs.size() > 0; i++) begin
            g = obs.pop_front();
            vecs++;
            if (g !== mk(base + 1 + i, 2'd0, ad[i], 12'd0, 1'b0)) begin
                errs++;
                $display("FAIL reset_mid read%0d: got cyc=%0d kind=%0d addr=%0d, need cyc=%0d kind=0 addr=%0d",
                         i, g.cyc, g.kind, g.addr, base + 1 + i, ad[i]);
            end
        end
        vecs++;
        if (result_a !== exp_result) begin
            errs++;
            $display("FAIL reset_mid result: got %h, need %h", result_a, exp_result);
        end
    endtask

    task automatic test_default_timeout();
        int base;
        int c;
        int nr = 0;
        int wr = 0;
        int first = -1;
        int second = -1;
        int done_c = -1;
        @(negedge clk);
        base = cyc;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            c = cyc - base;
            if (pread_b) begin
                nr++;
                if (first < 0)
                    first = c;
                else if (second < 0)
                    second = c;
            end
            if (pwrite_b)
                wr++;
            if (done_b) begin
                done_c = c;
                break;
            end
            @(negedge clk);
        end
        vecs++;
        if (nr != 1024) begin
            errs++;
            $display("FAIL dflt reads: got %0d, need 1024", nr);
        end
        vecs++;
        if (first != 1 || second != 6) begin
            errs++;
            $display("FAIL dflt spacing: got %0d,%0d, need 1,6", first, second);
        end
        vecs++;
        if (done_c != 5117) begin
            errs++;
            $display("FAIL dflt done_cycle: got %0d, need 5117", done_c);
        end
        vecs++;
        if (wr != 0 || timeout_err_b !== 1'b1 || result_b !== 12'h000) begin
            errs++;
            $display("FAIL dflt end: got wr=%0d err=%b res=%h, need 0 1 000",
                     wr, timeout_err_b, result_b);
        end
    endtask

    initial begin
        test_reset();
        test_txn("basic", 8'h0C, 8'h22, 0, 32'h0);
        test_txn("max", 8'hFF, 8'hFF, 0, 32'h0);
        test_txn("interval", 8'h80, 8'h7F, 2, 32'h0);
        test_txn("timeout", 8'h11, 8'h22, 99, 32'h0);
        test_txn("err_clear", 8'h01, 8'h02, 0, 32'h0);
        test_txn("start_ignored", 8'h33, 8'h44, 2, 32'h0000_0F2E);
        test_reset_mid();
        test_txn("after_reset", 8'h05, 8'h06, 1, 32'h0);
        test_default_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/io_poll_master.md
IO_POLL_MASTER -- requirements
Module: io_poll_master

Interface
REQ-001 Parameter: POLL_INTERVAL, default 4, idle cycles between consecutive status polls (legal range 1..255).
REQ-002 Parameter: TIMEOUT_POLLS, default 1024, maximum status reads before abort (legal range 1..65535).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to run one poll/read/sum/write transaction.
REQ-006 busy  output  1  high from the cycle after an accepted start through the DONE or ERR state.
REQ-007 done  output  1  one-cycle pulse marking the end of a transaction, whether successful or timed out.
REQ-008 timeout_err  output  1  sticky error flag, set on poll timeout and cleared by the next accepted start.
REQ-009 result  output  12  last value written to the LED register.
REQ-010 pread  output  1  bus read strobe.
REQ-011 pwrite  output  1  bus write strobe.
REQ-012 addr  output  2  bus address: 00 status, 01 LED, 10 switch low byte, 11 switch high byte.
REQ-013 pwritedata  output  12  bus write data.
REQ-014 preaddata  input  32  bus read data, valid combinationally in the same cycle pread is high.

Function
REQ-015 The block SHALL implement the states IDLE, POLL_RD, POLL_WAIT, RD_HI, RD_LO, WR_LED, DONE and ERR; bus outputs SHALL be decoded from the state register only (Moore outputs).
REQ-016 IDLE: pread=0, pwrite=0, addr=00, pwritedata=0, busy=0; start=1 moves to POLL_RD, clears timeout_err and clears the poll counter.
REQ-017 start SHALL be ignored in every state except IDLE.
REQ-018 POLL_RD, one cycle: pread=1, addr=00, preaddata[1] sampled.
- preaddata[1]=1 -> RD_HI.
- Otherwise, if the poll counter equals TIMEOUT_POLLS-1 -> ERR.
- Otherwise the poll counter increments and the state moves to POLL_WAIT, with the gap counter loaded to POLL_INTERVAL-1.
REQ-019 POLL_WAIT: all strobes 0; the gap counter decrements each cycle; at zero -> POLL_RD. This gives exactly POLL_INTERVAL idle cycles between status reads.
REQ-020 RD_HI, one cycle: pread=1, addr=11; capture hi=preaddata[7:0]; -> RD_LO.
REQ-021 RD_LO, one cycle: pread=1, addr=10; capture lo=preaddata[7:0]; -> WR_LED.
REQ-022 WR_LED, one cycle: pwrite=1, addr=01, pwritedata={3'b0, hi+lo} (9-bit unsigned sum, no overflow possible); result is updated with the same value; -> DONE.
REQ-023 DONE: done=1 for one cycle; -> IDLE.
REQ-024 ERR: done=1 and timeout_err set for one cycle; -> IDLE; result is unchanged.
REQ-025 pread and pwrite SHALL never be high in the same cycle.
REQ-026 Bits preaddata[31:8] SHALL be ignored in all states; only bit [1] of preaddata is used in POLL_RD.
REQ-027 Latency: with start accepted at cycle 0 and status ready on the first poll, POLL_RD occurs at cycle 1, RD_HI at 2, RD_LO at 3, WR_LED at 4 and the done pulse at 5.
REQ-028 A timeout SHALL occur after exactly TIMEOUT_POLLS status reads that all return bit1=0, with done asserted in the cycle after the last read.

Reset
REQ-029 On reset, the block SHALL set state=IDLE and clear busy, done, timeout_err, result, pread, pwrite, addr, pwritedata, hi, lo, the poll counter and the gap counter, all to 0.
REQ-030 Reset asserted mid-transaction SHALL abort the transaction with no further bus strobes from the following cycle; no done pulse is produced.

Verification
REQ-031 Status=0x2 on first poll, hi=0x0C, lo=0x22 -> reads at addresses 00, 11, 10 in cycles 1-3; write at 01 with pwritedata=0x02E in cycle 4; done in cycle 5; result=0x02E.
REQ-032 hi=0xFF, lo=0xFF -> pwritedata=0x1FE, result=0x1FE.
REQ-033 POLL_INTERVAL=2, status bit1 becomes 1 on the 3rd read -> status reads at cycles 1, 4 and 7; write at cycle 10; done at cycle 11.
REQ-034 TIMEOUT_POLLS=4, status always 0 -> exactly 4 status reads, no write, done and timeout_err both high at ERR, result unchanged; the next start clears timeout_err.
REQ-035 start pulsed while in POLL_WAIT -> no effect: exactly one done pulse per accepted start.
REQ-036 reset asserted in RD_LO -> the next cycle shows pread=0, pwrite=0, busy=0 and state IDLE, with no LED write issued.
